// File: rtl/rw_mode_scheduler.sv
// rw_mode_scheduler: channel-level read/write mode scheduler.
// Picks when the channel flips between RD and WR mode using write-queue watermarks,
// a minimum CAS burst per mode and read-starvation protection. After each flip the
// channel is blanked for SETTLE cycles before CAS issue may resume.
// SETTLE must be at least 2.
module rw_mode_scheduler #(
    parameter int unsigned RQ_DEPTH        = 32,
    parameter int unsigned WQ_DEPTH        = 32,
    parameter int unsigned HI_WM           = 24,
    parameter int unsigned LO_WM           = 8,
    parameter int unsigned MIN_BURST       = 4,
    parameter int unsigned RD_STARVE_LIMIT = 64,
    parameter int unsigned SETTLE          = 2,
    parameter int unsigned NUM_RANKS       = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [$clog2(RQ_DEPTH+1)-1:0]                        rdQueueCount,
    input  logic [$clog2(WQ_DEPTH+1)-1:0]                        wrQueueCount,
    input  logic                                                 casIssued,
    input  logic                                                 casIsWrite,
    input  logic [((NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1)-1:0] casRank,
    input  logic                                                 DQTurnaroundFree,
    output logic                                                 channelMode,
    output logic                                                 rankChanged,
    output logic                                                 casEnable,
    output logic                                                 casViolation
);

    localparam int unsigned WqW     = $clog2(WQ_DEPTH + 1);
    localparam int unsigned RankW   = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1;
    localparam int unsigned BurstW  = $clog2(MIN_BURST + 1);
    localparam int unsigned StarveW = $clog2(RD_STARVE_LIMIT + 1);
    localparam int unsigned SettleW = $clog2(SETTLE + 1);

    localparam logic [WqW-1:0]     HiWm       = WqW'(HI_WM);
    localparam logic [WqW-1:0]     LoWm       = WqW'(LO_WM);
    localparam logic [WqW-1:0]     WqFull     = WqW'(WQ_DEPTH);
    localparam logic [BurstW-1:0]  BurstMax   = BurstW'(MIN_BURST);
    localparam logic [StarveW-1:0] StarveMax  = StarveW'(RD_STARVE_LIMIT);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE - 1);

    typedef enum logic [1:0] {
        StRd,
        StRd2Wr,
        StWr,
        StWr2Rd
    } state_e;

    state_e             state;
    logic [RankW-1:0]   last_rank;
    logic [BurstW-1:0]  burst_cnt;
    logic [StarveW-1:0] starve_cnt;
    logic [SettleW-1:0] settle_cnt;

    logic rd_empty;
    logic wr_empty;
    logic wr_full;
    logic cas_acc;
    logic cas_bad;
    logic cas_good;
    logic rd_exit;
    logic wr_exit;

    // CAS gating, CAS classification and mode-exit decisions from registered state
    always_comb begin
        casEnable = rst && ((state == StRd) || (state == StWr)) && DQTurnaroundFree;
        rd_empty  = (rdQueueCount == '0);
        wr_empty  = (wrQueueCount == '0);
        wr_full   = (wrQueueCount == WqFull);
        // An enabled CAS defers any switch decision by a cycle, even a bad one
        cas_acc   = casIssued && casEnable;
        cas_bad   = casIssued && (!casEnable || (casIsWrite != channelMode));
        cas_good  = cas_acc && !cas_bad;
        // A full write queue overrides the minimum burst
        rd_exit   = !wr_empty &&
                    (((wrQueueCount >= HiWm) && (burst_cnt == BurstMax)) || rd_empty || wr_full);
        wr_exit   = wr_empty ||
                    ((wrQueueCount <= LoWm) && !rd_empty && (burst_cnt == BurstMax)) ||
                    ((starve_cnt == StarveMax) && !wr_full);
    end

    // Mode FSM with registered outputs, burst/starve/settle counters and rank tracking
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= StRd;
            channelMode  <= 1'b0;
            rankChanged  <= 1'b0;
            casViolation <= 1'b0;
            last_rank    <= '0;
            burst_cnt    <= '0;
            starve_cnt   <= '0;
            settle_cnt   <= '0;
        end else begin
            if (cas_bad) begin
                casViolation <= 1'b1;
            end
            if (cas_good) begin
                rankChanged <= (casRank != last_rank);
                last_rank   <= casRank;
            end

            unique case (state)
                StRd: begin
                    starve_cnt <= '0;
                    if (cas_good && (burst_cnt != BurstMax)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (!cas_acc && rd_exit) begin
                        state       <= StRd2Wr;
                        channelMode <= 1'b1;
                        settle_cnt  <= SettleLoad;
                        burst_cnt   <= '0;
                    end
                end
                StWr: begin
                    if (cas_good && (burst_cnt != BurstMax)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                    if (!cas_acc && wr_exit) begin
                        state       <= StWr2Rd;
                        channelMode <= 1'b0;
                        settle_cnt  <= SettleLoad;
                        burst_cnt   <= '0;
                        starve_cnt  <= '0;
                    end else if (rd_empty) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != StarveMax) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                StRd2Wr: begin
                    starve_cnt <= '0;
                    if (settle_cnt == '0) begin
                        state <= StWr;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                StWr2Rd: begin
                    starve_cnt <= '0;
                    if (settle_cnt == '0) begin
                        state <= StRd;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= StRd;
                end
            endcase
        end
    end

endmodule

// File: doc/rw_mode_scheduler.md
Name: rw_mode_scheduler

Overview:
- Channel-level read/write mode scheduler. Sits directly upstream of the DQ turnaround grant stage.
- Decides when the channel switches between read and write mode, using write-queue watermarks, a minimum CAS burst and read-starvation protection.
- Drives channelMode (1 = WR, 0 = RD) and rankChanged into the turnaround stage, and consumes its DQTurnaroundFree to gate CAS issue.
- The channel controller issues CAS only when casEnable is high.

Parameters:
- RQ_DEPTH, 32: read queue depth; count width is $clog2(RQ_DEPTH+1).
- WQ_DEPTH, 32: write queue depth; count width is $clog2(WQ_DEPTH+1).
- HI_WM, 24: write count at or above which RD mode must switch to WR.
- LO_WM, 8: write count at or below which WR mode may return to RD.
- MIN_BURST, 4: CAS commands that must issue in a mode before a watermark-driven switch.
- RD_STARVE_LIMIT, 64: WR-mode cycles with reads pending before RD is forced.
- SETTLE, 2: blanking cycles after a mode toggle; must be ≥ 2.
- NUM_RANKS, 2: rank count; rank width is $clog2(NUM_RANKS), minimum 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- rdQueueCount, in, $clog2(RQ_DEPTH+1): pending reads.
- wrQueueCount, in, $clog2(WQ_DEPTH+1): pending writes.
- casIssued, in, 1: a CAS was issued this cycle.
- casIsWrite, in, 1: the issued CAS is a write.
- casRank, in, rank width: rank of the issued CAS.
- DQTurnaroundFree, in, 1: turnaround window clear (from the downstream stage).
- channelMode, out, 1: current mode; 1 = WR, 0 = RD.
- rankChanged, out, 1: the last issued CAS targeted a different rank than the CAS before it.
- casEnable, out, 1: CAS issue permitted this cycle.
- casViolation, out, 1: sticky protocol-error flag.

Behaviour:
- Reset (sampled only on a clk edge with rst = 0): state = RD, channelMode = 0, rankChanged = 0, casEnable = 0, casViolation = 0, lastRank = 0, burstCnt = 0, starveCnt = 0, settleCnt = 0. Reset asserted mid-operation, including during SETTLE, aborts everything and returns to these values on the next edge.
- FSM states: RD, RD2WR, WR, WR2RD.
- casEnable = (state == RD or state == WR) and DQTurnaroundFree. It is combinational from registered state.
- burstCnt counts accepted CAS (casIssued and casEnable) in the current mode, saturates at MIN_BURST, and is cleared on every toggle.
- Leaving RD to RD2WR requires wrQueueCount > 0 and one of:
  - wrQueueCount ≥ HI_WM and burstCnt == MIN_BURST;
  - rdQueueCount == 0;
  - wrQueueCount == WQ_DEPTH (overrides MIN_BURST).
- Leaving WR to WR2RD requires one of:
  - wrQueueCount == 0;
  - wrQueueCount ≤ LO_WM, rdQueueCount > 0 and burstCnt == MIN_BURST;
  - starveCnt == RD_STARVE_LIMIT and wrQueueCount < WQ_DEPTH.
- On a transition edge: channelMode toggles on that same edge, settleCnt loads SETTLE-1, and burstCnt clears.
- RD2WR / WR2RD: settleCnt decrements each cycle; at 0 the FSM enters WR / RD respectively. casEnable stays 0 for exactly SETTLE cycles, then additionally waits for DQTurnaroundFree.
- No switch is evaluated in a cycle with an accepted CAS. The decision is deferred one cycle.
- starveCnt:
  - increments in WR when rdQueueCount > 0, saturating at RD_STARVE_LIMIT;
  - clears when rdQueueCount == 0, on entry to WR2RD, and in any non-WR state.
- rankChanged:
  - on an accepted CAS, it registers (casRank != lastRank) and lastRank <= casRank;
  - it holds otherwise, so it is valid from the cycle after the CAS until the next CAS;
  - the first CAS after reset compares against rank 0.
- casViolation sets and stays set until reset when either:
  - casIssued while casEnable == 0; or
  - casIssued with casIsWrite != channelMode.
  - A violating CAS updates neither burstCnt nor rankChanged/lastRank.
- Simultaneous conditions:
  - full WQ in RD: switch to WR;
  - both exit conditions true in WR: exit (single transition);
  - wrQueueCount == 0 in RD: stay in RD.

Test Plan:
1. Reset, then rd = 5, wr = 0: channelMode stays 0. casEnable = 1 while DQTurnaroundFree = 1. No toggle for 100 cycles.
2. RD with 4 accepted reads, wr raised to 24: channelMode rises on the next edge. casEnable is 0 for 2 cycles, then follows DQTurnaroundFree. burstCnt = 0.
3. WR mode, wr = 20, rd = 3, writes held off: after 64 cycles starveCnt saturates, mode flips to RD on the next edge; the check is repeated with wr = 32, where no flip occurs.
4. wr = 32 in RD with burstCnt = 1: immediate switch to WR, MIN_BURST overridden.
5. Accepted CAS ranks 0, 0, 1, 1, 0: rankChanged reads 0, 0, 1, 0, 1, each valid one cycle after its CAS.
6. casIssued during RD2WR settle, and a write CAS issued in RD mode: casViolation = 1 and sticky; burstCnt and rankChanged unchanged. rst = 0 mid-settle clears everything to RD on the next edge.
